// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock/soft-reset inputs and sequenced reset/status outputs of one PLL supervisor.
interface pll_reset_sequencer_if #(parameter int NUM_CHANNELS = 3);
  logic pll_locked;
  logic soft_reset;
  logic pll_rst;
  logic [NUM_CHANNELS-1:0] chan_reset_n;
  logic all_ready;
  logic fault;
  logic [3:0] retry_count;
  logic [2:0] state;
  modport master (input pll_locked, soft_reset, output pll_rst, chan_reset_n, all_ready, fault, retry_count, state);
  modport slave (output pll_locked, soft_reset, input pll_rst, chan_reset_n, all_ready, fault, retry_count, state);
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, qualifies lock, then releases channel resets one by one.
module pll_reset_sequencer #(
  parameter int NUM_CHANNELS = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES = 3
) (
  input logic clk,
  input logic reset_n,
  pll_reset_sequencer_if.master bus
);
  localparam int M0 = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int M1 = STAGGER_CYCLES > LOCK_TIMEOUT_CYCLES ? STAGGER_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(M0 > M1 ? M0 : M1) + 1;
  localparam logic [NUM_CHANNELS-1:0] ONE = NUM_CHANNELS'(1);
  typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT} state_t;
  state_t st;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [NUM_CHANNELS-1:0] chan, chan_nxt;
  logic pll_rst, all_ready, fault, lock_s;
  logic [3:0] retry;
  assign lock_s = sync[1];
  assign chan_nxt = (chan << 1) | ONE;
  assign bus.pll_rst = pll_rst;
  assign bus.chan_reset_n = chan;
  assign bus.all_ready = all_ready;
  assign bus.fault = fault;
  assign bus.retry_count = retry;
  assign bus.state = st;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      st <= PLL_RESET;
      cnt <= '0;
      chan <= '0;
      pll_rst <= 1'b1;
      all_ready <= 1'b0;
      fault <= 1'b0;
      retry <= '0;
    end else begin
      sync <= {sync[0], bus.pll_locked};
      cnt <= cnt + 1'b1;
      if (bus.soft_reset) begin
        st <= PLL_RESET;
        cnt <= '0;
        chan <= '0;
        pll_rst <= 1'b1;
        all_ready <= 1'b0;
        fault <= 1'b0;
        retry <= '0;
      end else
        case (st)
          PLL_RESET:
            if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
              st <= WAIT_LOCK;
              cnt <= '0;
              pll_rst <= 1'b0;
            end
          WAIT_LOCK:
            if (lock_s) begin
              st <= STABLE;
              cnt <= '0;
            end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
              cnt <= '0;
              pll_rst <= 1'b1;
              if (retry >= 4'(MAX_RETRIES)) begin
                st <= FAULT;
                fault <= 1'b1;
              end else begin
                st <= PLL_RESET;
                retry <= retry + 1'b1;
              end
            end
          STABLE:
            if (!lock_s) begin
              st <= WAIT_LOCK;
              cnt <= '0;
            end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
              cnt <= '0;
              chan <= ONE;
              if (NUM_CHANNELS == 1) begin
                st <= RUN;
                all_ready <= 1'b1;
                retry <= '0;
              end else st <= RELEASE;
            end
          // lock loss outranks a pending stagger step
          RELEASE, RUN:
            if (!lock_s) begin
              st <= PLL_RESET;
              cnt <= '0;
              chan <= '0;
              pll_rst <= 1'b1;
              all_ready <= 1'b0;
              retry <= retry + {3'd0, retry != 4'hf};
            end else if (st == RUN) begin
              cnt <= '0;
              retry <= '0;
            end else if (cnt == CW'(STAGGER_CYCLES - 1)) begin
              cnt <= '0;
              chan <= chan_nxt;
              if (&chan_nxt) begin
                st <= RUN;
                all_ready <= 1'b1;
                retry <= '0;
              end
            end
          FAULT: cnt <= '0;
          default: begin
            st <= PLL_RESET;
            cnt <= '0;
            pll_rst <= 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: three configurations checked every cycle against a phase/elapsed-time model,
// plus directed timing checks for bring-up, lock loss, timeout fault, async reset and single channel.
module tb_pll_reset_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic lk [3];
  logic sf [3];
  int vectors = 0, miscompares = 0;
  int prc [3] = '{16, 16, 4};
  int lsc [3] = '{1024, 40, 30};
  int sc [3] = '{64, 6, 1};
  int ltc [3] = '{65536, 100, 200};
  int mr [3] = '{3, 2, 3};
  int nc [3] = '{3, 3, 1};
  int rate [3] = '{2500, 120, 50};
  int ph [3], e [3], rt [3], rel [3];
  logic d1 [3], ls [3];
  int pulses = 0;
  logic pr1_prev = 1'b0;

  always #5 clk = ~clk;

  pll_reset_sequencer_if #(.NUM_CHANNELS(3)) b0 ();
  pll_reset_sequencer_if #(.NUM_CHANNELS(3)) b1 ();
  pll_reset_sequencer_if #(.NUM_CHANNELS(1)) b2 ();
  assign b0.pll_locked = lk[0];
  assign b1.pll_locked = lk[1];
  assign b2.pll_locked = lk[2];
  assign b0.soft_reset = sf[0];
  assign b1.soft_reset = sf[1];
  assign b2.soft_reset = sf[2];

  pll_reset_sequencer u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  pll_reset_sequencer #(.LOCK_STABLE_CYCLES(40), .STAGGER_CYCLES(6), .LOCK_TIMEOUT_CYCLES(100),
    .MAX_RETRIES(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  pll_reset_sequencer #(.NUM_CHANNELS(1), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(30), .STAGGER_CYCLES(1),
    .LOCK_TIMEOUT_CYCLES(200)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(logic [2:0] s, logic p, logic a, logic f, logic [3:0] r, logic [15:0] c);
    return {6'd0, s, p, a, f, r, c};
  endfunction

  // expected outputs follow directly from the phase and the number of channels released
  function automatic logic [31:0] expv(int i);
    return pk(3'(ph[i]), ph[i] == 0 || ph[i] == 5, ph[i] == 4, ph[i] == 5, 4'(rt[i]), 16'((1 << rel[i]) - 1));
  endfunction

  task automatic go(input int i, input int p);
    ph[i] = p;
    e[i] = 0;
  endtask

  task automatic lose(input int i);
    rel[i] = 0;
    rt[i] = rt[i] < 15 ? rt[i] + 1 : 15;
    go(i, 0);
  endtask

  task automatic step(input int i);
    logic l;
    l = ls[i];
    ls[i] = d1[i];
    d1[i] = lk[i];
    if (sf[i]) begin
      go(i, 0);
      rt[i] = 0;
      rel[i] = 0;
    end else begin
      e[i]++;
      case (ph[i])
        0: if (e[i] == prc[i]) go(i, 1);
        1: if (l) go(i, 2);
           else if (e[i] == ltc[i]) begin
             if (rt[i] >= mr[i]) go(i, 5);
             else begin
               rt[i]++;
               go(i, 0);
             end
           end
        2: if (!l) go(i, 1);
           else if (e[i] == lsc[i]) begin
             rel[i] = 1;
             go(i, nc[i] == 1 ? 4 : 3);
           end
        3: if (!l) lose(i);
           else if (e[i] == sc[i]) begin
             rel[i]++;
             e[i] = 0;
             if (rel[i] == nc[i]) go(i, 4);
           end
        4: if (!l) lose(i);
        default: ;
      endcase
      if (ph[i] == 4) rt[i] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    for (int i = 0; i < 3; i++)
      if (!reset_n) begin
        ph[i] = 0; e[i] = 0; rt[i] = 0; rel[i] = 0; d1[i] = 1'b0; ls[i] = 1'b0;
      end else step(i);
  end

  initial forever begin
    @(negedge clk);
    check("u0", pk(b0.state, b0.pll_rst, b0.all_ready, b0.fault, b0.retry_count, 16'(b0.chan_reset_n)), expv(0));
    check("u1", pk(b1.state, b1.pll_rst, b1.all_ready, b1.fault, b1.retry_count, 16'(b1.chan_reset_n)), expv(1));
    check("u2", pk(b2.state, b2.pll_rst, b2.all_ready, b2.fault, b2.retry_count, 16'(b2.chan_reset_n)), expv(2));
    if (b1.pll_rst && !pr1_prev && !b1.fault) pulses++;
    pr1_prev = b1.pll_rst;
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      lk[i] = 1'b0;
      sf[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_u0", pk(b0.state, b0.pll_rst, b0.all_ready, b0.fault, b0.retry_count, 16'(b0.chan_reset_n)), 32'h0040_0000);
    check("rst_u2", pk(b2.state, b2.pll_rst, b2.all_ready, b2.fault, b2.retry_count, 16'(b2.chan_reset_n)), 32'h0040_0000);
    reset_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (b0.pll_rst && n < 100);
    check("pll_rst_len", n, 16);
    repeat (84) @(negedge clk);
    lk[0] = 1'b1;
    lk[2] = 1'b1;
    n = 0;
    while (!b0.chan_reset_n[0] && n < 3000) begin @(negedge clk); n++; end
    check("rel0_delay", n, 2 + 1 + 1024);
    n = 0;
    while (!b0.chan_reset_n[1] && n < 200) begin @(negedge clk); n++; end
    check("rel1_gap", n, 64);
    check("rel1_pattern", 32'(b0.chan_reset_n), 3'b011);
    n = 0;
    while (!b0.chan_reset_n[2] && n < 200) begin @(negedge clk); n++; end
    check("rel2_gap", n, 64);
    check("run_ready", 32'(b0.all_ready), 1);
    check("run_retry", 32'(b0.retry_count), 0);
    // never-lock configuration has been sitting in its sticky fault
    check("flt_fault", 32'(b1.fault), 1);
    check("flt_state", 32'(b1.state), 5);
    check("flt_pll_rst", 32'(b1.pll_rst), 1);
    check("flt_retry", 32'(b1.retry_count), 2);
    check("flt_pulses", pulses, 3);
    sf[1] = 1'b1;
    @(negedge clk);
    sf[1] = 1'b0;
    check("soft_state", 32'(b1.state), 0);
    check("soft_fault", 32'(b1.fault), 0);
    check("soft_retry", 32'(b1.retry_count), 0);
    // single channel: release and all_ready on the same edge
    lk[2] = 1'b0;
    repeat (10) @(negedge clk);
    lk[2] = 1'b1;
    n = 0;
    while (!b2.chan_reset_n[0] && n < 500) begin @(negedge clk); n++; end
    check("one_delay", n, 2 + 1 + 30);
    check("one_ready", 32'(b2.all_ready), 1);
    // lock loss in RUN
    lk[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("loss_chan", 32'(b0.chan_reset_n), 0);
    check("loss_ready", 32'(b0.all_ready), 0);
    check("loss_retry", 32'(b0.retry_count), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (b0.pll_rst && n < 100);
    check("loss_pll_rst_len", n, 16);
    repeat (10) @(negedge clk);
    lk[0] = 1'b1;
    n = 0;
    while (b0.state != 3'd2 && n < 10) begin @(negedge clk); n++; end
    check("relock_stable", n, 3);
    // glitch 500 cycles into the stable count
    repeat (500) @(negedge clk);
    lk[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_state", 32'(b0.state), 1);
    check("glitch_chan", 32'(b0.chan_reset_n), 0);
    check("glitch_retry", 32'(b0.retry_count), 1);
    lk[0] = 1'b1;
    n = 0;
    while (!b0.chan_reset_n[0] && n < 3000) begin @(negedge clk); n++; end
    check("glitch_rel0", n, 2 + 1 + 1024);
    n = 0;
    while (!b0.all_ready && n < 300) begin @(negedge clk); n++; end
    check("relock_ready", n, 128);
    check("relock_retry", 32'(b0.retry_count), 0);
    // async reset while one channel is released
    lk[0] = 1'b0;
    repeat (30) @(negedge clk);
    lk[0] = 1'b1;
    n = 0;
    while (b0.chan_reset_n != 3'b001 && n < 2000) begin @(negedge clk); n++; end
    check("ar_one_rel", 32'(b0.chan_reset_n), 3'b001);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("ar_chan", 32'(b0.chan_reset_n), 0);
    check("ar_state", 32'(b0.state), 0);
    check("ar_pll_rst", 32'(b0.pll_rst), 1);
    #1 reset_n = 1'b1;
    n = 0;
    while (!b0.all_ready && n < 2000) begin @(negedge clk); n++; end
    check("ar_restart", n, 1 + 16 + 1 + 1024 + 128);
    check("ar_retry", 32'(b0.retry_count), 0);
    // random lock flaps and soft resets against the model
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, rate[i]) == 0) lk[i] = ~lk[i];
        sf[i] = ($urandom_range(0, 799) == 0);
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Parametrised PLL supervisor and reset sequencer, one instance per board-level PLL; sits between the PLL primitive wrapper and the design's clock domains.
- Pulses the PLL reset and waits for lock, then requires lock to stay stable before releasing NUM_CHANNELS downstream resets one by one (e.g. SDRAM phy, controller, test logic).
- On loss of lock it re-asserts every channel reset and retries the PLL; after MAX_RETRIES failed lock attempts it enters a sticky fault state.
- Runs entirely on the free-running reference clock, never on a PLL output.

Parameters:
- NUM_CHANNELS, 3: number of sequenced reset outputs (1..16).
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before the first release (>=1).
- STAGGER_CYCLES, 64: cycles between successive channel releases (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles to wait for lock per attempt (>=1).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (0..15).

Ports:
- clk, in, 1: free-running reference clock (PLL refclk).
- reset_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL locked; asynchronous to clk.
- soft_reset, in, 1: synchronous request to restart the whole sequence; level-sensitive.
- pll_rst, out, 1: active-high reset to the PLL.
- chan_reset_n, out, NUM_CHANNELS: per-channel active-low resets; bit 0 is released first.
- all_ready, out, 1: high while in RUN.
- fault, out, 1: high while in FAULT.
- retry_count, out, 4: failed lock attempts since the last entry to RUN or reset.
- state, out, 3: encoded state for debug; PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5.

Behaviour:
- Reset values while reset_n is low: state=PLL_RESET, pll_rst=1, chan_reset_n=all 0, all_ready=0, fault=0, retry_count=0, all counters 0, synchroniser flops 0.
- reset_n is asserted asynchronously and deasserted on a clk edge.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser to form lock_s. All decisions use lock_s, so there is 2 cycles of latency from pll_locked.
- One shared counter; it clears to 0 on every state transition.
- PLL_RESET:
  - pll_rst=1 and chan_reset_n=0.
  - After the counter reaches PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst is high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1, go to STABLE.
  - Else, if the counter reaches LOCK_TIMEOUT_CYCLES-1, count a failed attempt:
    - if retry_count==MAX_RETRIES, go to FAULT;
    - otherwise increment retry_count and go to PLL_RESET.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK. The counter restarts and this does not count as a retry.
  - If the counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1, go to RELEASE and release chan_reset_n[0] on that same transition edge.
- RELEASE:
  - Every STAGGER_CYCLES cycles, release the next channel bit.
  - Released bits stay high (thermometer pattern; bits never release out of order).
  - When the last bit is released, go to RUN on that edge.
  - With NUM_CHANNELS=1, go straight from STABLE to RUN.
- RUN:
  - all_ready=1 and retry_count clears to 0.
  - Stay while lock_s=1.
- Loss of lock in RELEASE or RUN:
  - On the next edge drive chan_reset_n=all 0 and all_ready=0.
  - Go to PLL_RESET and increment retry_count; saturate at 15.
- FAULT:
  - fault=1, pll_rst=1, chan_reset_n=all 0.
  - Sticky: exits only on reset_n or soft_reset.
- soft_reset=1 in any state:
  - Next edge: state=PLL_RESET, counter=0, retry_count=0, chan_reset_n=all 0, fault=0.
  - Held high, the sequence stays in PLL_RESET with the counter held at 0.
  - soft_reset has priority over all other transitions.
- Simultaneous events on one edge:
  - A lock loss on the same edge as a RELEASE step: the loss wins and no bit is released.
  - A lock arriving on the timeout edge: the lock wins (go to STABLE).
- Counter width: clog2 of the largest cycle parameter plus 1. Comparisons must not wrap.

Test Plan:
- Nominal bring-up (defaults): pll_locked rises 100 cycles after reset_n.
  - Expect pll_rst high for 16 cycles.
  - Expect chan_reset_n[0] high 2+1024 cycles after the lock edge, then [1] and [2] at +64 and +128.
  - Expect all_ready=1 with the third release; retry_count=0.
- Lock glitch in STABLE: drop pll_locked for 3 cycles at 500 cycles into STABLE.
  - Expect return to WAIT_LOCK, then a fresh 1024-cycle stable count.
  - Expect retry_count unchanged and no channel released early.
- Lock loss in RUN: drop pll_locked.
  - Expect all chan_reset_n=0 and all_ready=0 within 3 cycles of the drop, pll_rst pulse of 16 cycles, retry_count=1.
  - After relock and full sequence, expect retry_count=0.
- Never lock (LOCK_TIMEOUT_CYCLES=100, MAX_RETRIES=2): keep pll_locked=0.
  - Expect 3 pll_rst pulses, then fault=1, state=5, pll_rst=1.
  - soft_reset for 1 cycle → state=0, fault=0, retry_count=0.
- Async reset mid-RELEASE: pulse reset_n low between any two clk edges while one channel is released.
  - Expect chan_reset_n=0 immediately, asynchronous to clk.
  - Expect a full sequence to restart after release.
- NUM_CHANNELS=1, STAGGER_CYCLES=1: after a stable lock, expect chan_reset_n[0]=1 and all_ready=1 on the same edge.
